board_sw_scan_sword: RTL and testbench

- Serial input scanner for board switches and buttons wired through a parallel-in/serial-out shift-register chain (74HC165 style).
- Counterpart of the serial LED/segment output path: it generates the load and shift clock, captures the serial bit stream, debounces across scans, and presents a stable parallel word to the system.
- Scans periodically or on request, and flags completed scans and debounced changes.

---
 rtl/board_sw_scan_sword.sv | 170 +++++++++++++++++
 tb/tb_board_sw_scan_sword.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_sw_scan_sword.sv
// board_sw_scan_sword: scanner for a 74HC165-style parallel-in/serial-out chain.
// Generates the load strobe and shift clock, assembles the serial stream into a
// word, and debounces it across consecutive scans before presenting it as data.
module board_sw_scan_sword #(
  parameter int CLK_FREQ       = 100,
  parameter int S_CLK_FREQ     = 25,
  parameter int DATA_BITS      = 16,
  parameter int SCAN_INTERVAL  = 1,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CODE_ENDIAN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_req,
  output logic                 s_clk,
  output logic                 s_load_n,
  input  logic                 s_di,
  output logic                 busy,
  output logic                 scan_done,
  output logic [DATA_BITS-1:0] raw,
  output logic [DATA_BITS-1:0] data,
  output logic                 changed
);

  // Half period of the shift clock in main-clock cycles.
  localparam int H         = CLK_FREQ / (2 * S_CLK_FREQ);
  localparam int INT_LIMIT = CLK_FREQ * SCAN_INTERVAL * 1000 - 1;
  localparam int INT_W     = (INT_LIMIT > 0) ? $clog2(INT_LIMIT + 1) : 1;
  localparam int PH_W      = (2 * H > 1) ? $clog2(2 * H) : 1;
  localparam int BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CNT_W     = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [INT_W-1:0] INT_LAST   = INT_W'(INT_LIMIT);
  localparam logic [PH_W-1:0]  LOAD_LAST  = PH_W'(2 * H - 1);
  localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(H - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] DB_MAX     = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [INT_W-1:0]     int_q, int_d;
  logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
  logic                 phase_q, phase_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] raw_q, raw_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CNT_W-1:0]     stable_q, stable_d;

  logic                 tick;
  logic [BIT_W-1:0]     samp_idx;
  logic                 data_upd;

  // State register: every flop of the scanner, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      int_q     <= '0;
      ph_cnt_q  <= '0;
      phase_q   <= 1'b0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      raw_q     <= '0;
      data_q    <= '0;
      stable_q  <= '0;
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      ph_cnt_q  <= ph_cnt_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      raw_q     <= raw_d;
      data_q    <= data_d;
      stable_q  <= stable_d;
    end
  end

  // Next state: interval timer, load/shift sequencing, bit capture and debounce.
  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    raw_d     = raw_q;
    data_d    = data_q;
    stable_d  = stable_q;
    data_upd  = 1'b0;

    tick  = (int_q == INT_LAST);
    int_d = tick ? '0 : int_q + INT_W'(1);

    samp_idx = (CODE_ENDIAN != 0) ? (BIT_LAST - bit_idx_q) : bit_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (tick || scan_req) begin
          state_d  = ST_LOAD;
          ph_cnt_d = '0;
        end
      end

      ST_LOAD: begin
        if (ph_cnt_q == LOAD_LAST) begin
          state_d   = ST_SHIFT;
          ph_cnt_d  = '0;
          phase_d   = 1'b0;
          bit_idx_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      ST_SHIFT: begin
        if (ph_cnt_q == PHASE_LAST) begin
          ph_cnt_d = '0;
          if (!phase_q) begin
            shreg_d[samp_idx] = s_di;
            phase_d           = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_idx_q == BIT_LAST) begin
              state_d = ST_DONE;
            end else begin
              bit_idx_d = bit_idx_q + BIT_W'(1);
            end
          end
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      ST_DONE: begin
        raw_d = shreg_q;
        if (shreg_q == raw_q) begin
          stable_d = (stable_q >= DB_MAX) ? DB_MAX : stable_q + CNT_W'(1);
        end else begin
          stable_d = CNT_W'(1);
        end
        if ((stable_d >= DB_MAX) && (shreg_q != data_q)) begin
          data_upd = 1'b1;
          data_d   = shreg_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: chain strobes and status flags decoded from the current state.
  always_comb begin
    s_clk     = (state_q == ST_SHIFT) && phase_q;
    s_load_n  = (state_q != ST_LOAD);
    busy      = (state_q != ST_IDLE);
    scan_done = (state_q == ST_DONE);
    changed   = (state_q == ST_DONE) && data_upd;
  end

  assign raw  = raw_q;
  assign data = data_q;

endmodule

// File: tb/tb_board_sw_scan_sword.sv
// tb_board_sw_scan_sword: drives two scanners (one per bit order) from a shared
// switch word through behavioural 74HC165 chains, and compares every cycle
// against a scan-timeline model plus directed literal checks.
module tb_board_sw_scan_sword;

  localparam int CLK_FREQ      = 4;
  localparam int S_CLK_FREQ    = 1;
  localparam int N             = 16;
  localparam int SCAN_INTERVAL = 1;
  localparam int DB            = 4;
  localparam int H             = CLK_FREQ / (2 * S_CLK_FREQ);
  localparam int PERIOD        = CLK_FREQ * SCAN_INTERVAL * 1000;
  localparam int LAT           = 2 * H + 2 * H * N + 1;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         scan_req = 1'b0;
  logic [N-1:0] sw_word  = '0;
  int           cyc      = 0;
  int           total    = 0;
  int           bad      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word as it should appear in raw for a given bit order of the chain.
  function automatic logic [N-1:0] map_word(input logic [N-1:0] w, input int endian);
    logic [N-1:0] r;
    if (endian != 0) return w;
    for (int i = 0; i < N; i++) r[i] = w[N-1-i];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic         s_clk_o, s_load_n_o, s_di_i, busy_o, scan_done_o, changed_o;
    logic [N-1:0] raw_o, data_o;

    board_sw_scan_sword #(
      .CLK_FREQ      (CLK_FREQ),
      .S_CLK_FREQ    (S_CLK_FREQ),
      .DATA_BITS     (N),
      .SCAN_INTERVAL (SCAN_INTERVAL),
      .DEBOUNCE_SCANS(DB),
      .CODE_ENDIAN   (g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .scan_req (scan_req),
      .s_clk    (s_clk_o),
      .s_load_n (s_load_n_o),
      .s_di     (s_di_i),
      .busy     (busy_o),
      .scan_done(scan_done_o),
      .raw      (raw_o),
      .data     (data_o),
      .changed  (changed_o)
    );

    // Chain: latches the switches when load releases, MSB first, shifts on s_clk rise.
    int           sh   = N;
    logic [N-1:0] held = '0;
    always @(posedge s_clk_o or negedge s_load_n_o) begin
      if (!s_load_n_o) sh <= 0;
      else             sh <= sh + 1;
    end
    always @(posedge s_load_n_o) held <= sw_word;
    assign s_di_i = (sh < N) ? held[N-1-sh] : 1'b0;

    // Event counters used by the directed checks.
    int   load_cnt = 0, rise_cnt = 0, chg_cnt = 0, done_cnt = 0;
    logic sclk_prev = 1'b0, busy_prev = 1'b0;
    int   rise_log[$];
    always @(negedge clk) begin
      if (s_load_n_o === 1'b0) load_cnt++;
      if (s_clk_o === 1'b1 && sclk_prev !== 1'b1) rise_cnt++;
      sclk_prev = s_clk_o;
      if (changed_o === 1'b1) chg_cnt++;
      if (scan_done_o === 1'b1) done_cnt++;
      if (busy_o === 1'b1 && busy_prev !== 1'b1) rise_log.push_back(cyc);
      busy_prev = busy_o;
    end

    // Reference model: a scan is a fixed timeline of offsets k=1..LAT after its start.
    bit           model_on = 1'b0, in_scan = 1'b0, tick;
    int           k = 0, since = 0, stable_m = 0, new_stable, j;
    logic [N-1:0] cap = '0, raw_m = '0, data_m = '0;
    logic         e_busy, e_ld, e_sclk, e_done, e_chg;
    always @(negedge clk) begin
      if (model_on) begin
        e_busy = in_scan;
        e_ld   = !(in_scan && k <= 2 * H);
        e_sclk = 1'b0;
        if (in_scan && k > 2 * H && k <= 2 * H + 2 * H * N) begin
          j      = k - 2 * H - 1;
          e_sclk = (j % (2 * H)) >= H;
        end
        e_done     = in_scan && (k == LAT);
        e_chg      = 1'b0;
        new_stable = stable_m;
        if (in_scan && k == 2 * H) cap = map_word(sw_word, g);
        if (e_done) begin
          new_stable = (cap == raw_m) ? ((stable_m + 1 > DB) ? DB : stable_m + 1) : 1;
          e_chg      = (new_stable >= DB) && (cap != data_m);
        end
        check_output($sformatf("e%0d.busy", g), 64'(busy_o), 64'(e_busy));
        check_output($sformatf("e%0d.s_load_n", g), 64'(s_load_n_o), 64'(e_ld));
        check_output($sformatf("e%0d.s_clk", g), 64'(s_clk_o), 64'(e_sclk));
        check_output($sformatf("e%0d.scan_done", g), 64'(scan_done_o), 64'(e_done));
        check_output($sformatf("e%0d.changed", g), 64'(changed_o), 64'(e_chg));
        check_output($sformatf("e%0d.raw", g), 64'(raw_o), 64'(raw_m));
        check_output($sformatf("e%0d.data", g), 64'(data_o), 64'(data_m));
        if (e_done) begin
          raw_m    = cap;
          stable_m = new_stable;
          if (e_chg) data_m = cap;
        end
        tick = (since % PERIOD) == PERIOD - 1;
        since++;
        if (in_scan) begin
          if (k == LAT) in_scan = 1'b0;
          else          k++;
        end else if (tick || scan_req) begin
          in_scan = 1'b1;
          k       = 1;
        end
      end
      if (rst === 1'b1) begin
        in_scan  = 1'b0;
        k        = 0;
        raw_m    = '0;
        data_m   = '0;
        stable_m = 0;
        since    = 0;
        cap      = '0;
        model_on = 1'b1;
      end
    end
  end

  int lat, busy1, ld0, rs0, ch0, dn0, r0;
  logic [N-1:0] pool [3];

  task automatic wait_idle();
    int n = 0;
    while (g_inst[1].busy_o !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check_output("idle.timeout", 64'(1), 64'(0));
  endtask

  // One requested scan of word w; returns latency from the request cycle to scan_done.
  task automatic apply_stimulus(input logic [N-1:0] w);
    bit seen = 1'b0;
    wait_idle();
    sw_word  = w;
    scan_req = 1'b1;
    lat      = -1;
    busy1    = 0;
    for (int n = 0; n < LAT + 50 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = int'(g_inst[1].busy_o);
      if (g_inst[1].scan_done_o === 1'b1) begin
        seen = 1'b1;
        lat  = n;
      end
      if (scan_req) begin
        @(posedge clk); #1;
        scan_req = 1'b0;
      end
    end
    if (!seen) check_output("scan.timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check_output("rst.busy", 64'(g_inst[1].busy_o), 64'(0));
    check_output("rst.s_load_n", 64'(g_inst[1].s_load_n_o), 64'(1));
    check_output("rst.s_clk", 64'(g_inst[1].s_clk_o), 64'(0));
    check_output("rst.raw", 64'(g_inst[1].raw_o), 64'(0));
    check_output("rst.data", 64'(g_inst[1].data_o), 64'(0));

    // Single scan of a known word.
    ld0 = g_inst[1].load_cnt;
    rs0 = g_inst[1].rise_cnt;
    apply_stimulus(16'hA5C3);
    check_output("scan.latency", 64'(lat), 64'(69));
    check_output("scan.busy_next", 64'(busy1), 64'(1));
    check_output("scan.load_cycles", 64'(g_inst[1].load_cnt - ld0), 64'(4));
    check_output("scan.sclk_rises", 64'(g_inst[1].rise_cnt - rs0), 64'(16));
    check_output("scan.raw_e1", 64'(g_inst[1].raw_o), 64'h0000_0000_0000_A5C3);
    check_output("scan.raw_e0", 64'(g_inst[0].raw_o), 64'h0000_0000_0000_C3A5);

    // Debounce: data follows only on the fourth identical scan.
    ch0 = g_inst[1].chg_cnt;
    for (int s = 1; s <= 6; s++) begin
      apply_stimulus(16'h0001);
      if (s == 3) check_output("deb.data_s3", 64'(g_inst[1].data_o), 64'(0));
      if (s == 4) begin
        check_output("deb.data_s4", 64'(g_inst[1].data_o), 64'h1);
        check_output("deb.data_s4_e0", 64'(g_inst[0].data_o), 64'h8000);
        check_output("deb.chg_s4", 64'(g_inst[1].chg_cnt - ch0), 64'(1));
      end
    end
    check_output("deb.chg_total", 64'(g_inst[1].chg_cnt - ch0), 64'(1));

    // Bounce: alternating words never settle.
    ch0 = g_inst[1].chg_cnt;
    for (int s = 0; s < 6; s++) apply_stimulus((s % 2 == 0) ? 16'h00FF : 16'h0000);
    check_output("bounce.chg", 64'(g_inst[1].chg_cnt - ch0), 64'(0));
    check_output("bounce.data", 64'(g_inst[1].data_o), 64'h1);

    // Bit order: first serial bit lands in data[0] for the little-endian scanner.
    apply_stimulus(16'h8001);
    check_output("endian.8001", 64'(g_inst[0].raw_o), 64'h8001);
    apply_stimulus(16'h1234);
    check_output("endian.1234_e0", 64'(g_inst[0].raw_o), 64'h2C48);
    check_output("endian.1234_e1", 64'(g_inst[1].raw_o), 64'h1234);

    // Periodic scans with an idle bench.
    r0 = g_inst[1].rise_log.size();
    for (int n = 0; n < 2 * PERIOD + 1000 && g_inst[1].rise_log.size() < r0 + 2; n++) @(posedge clk);
    #1;
    if (g_inst[1].rise_log.size() < r0 + 2) check_output("periodic.timeout", 64'(0), 64'(1));
    else check_output("periodic.spacing",
                      64'(g_inst[1].rise_log[r0+1] - g_inst[1].rise_log[r0]), 64'(PERIOD));

    // A request while busy is dropped.
    wait_idle();
    dn0      = g_inst[1].done_cnt;
    r0       = g_inst[1].rise_log.size();
    sw_word  = 16'h5A5A;
    scan_req = 1'b1;
    @(posedge clk); #1 scan_req = 1'b0;
    repeat (30) @(posedge clk);
    #1 scan_req = 1'b1;
    @(posedge clk); #1 scan_req = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check_output("busyreq.scans", 64'(g_inst[1].done_cnt - dn0), 64'(1));
    check_output("busyreq.starts", 64'(g_inst[1].rise_log.size() - r0), 64'(1));
    check_output("busyreq.idle", 64'(g_inst[1].busy_o), 64'(0));

    // Reset during bit 7 of a scan.
    wait_idle();
    sw_word  = 16'h3C5A;
    scan_req = 1'b1;
    @(posedge clk); #1 scan_req = 1'b0;
    repeat (32) @(posedge clk);
    #1 rst = 1'b1;
    dn0 = g_inst[1].done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    check_output("midrst.s_clk", 64'(g_inst[1].s_clk_o), 64'(0));
    check_output("midrst.s_load_n", 64'(g_inst[1].s_load_n_o), 64'(1));
    check_output("midrst.busy", 64'(g_inst[1].busy_o), 64'(0));
    check_output("midrst.raw", 64'(g_inst[1].raw_o), 64'(0));
    check_output("midrst.data", 64'(g_inst[1].data_o), 64'(0));
    repeat (100) @(posedge clk);
    #1;
    check_output("midrst.no_done", 64'(g_inst[1].done_cnt - dn0), 64'(0));
    apply_stimulus(16'h3C5A);
    check_output("midrst.lat", 64'(lat), 64'(69));
    check_output("midrst.raw_after", 64'(g_inst[1].raw_o), 64'h3C5A);

    // Random requests and slowly changing switches, checked by the model.
    pool[0] = N'($urandom());
    pool[1] = N'($urandom());
    pool[2] = 16'h0F0F;
    sw_word = pool[0];
    repeat (6000) begin
      @(posedge clk); #1;
      scan_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) sw_word = pool[$urandom_range(0, 2)];
    end
    scan_req = 1'b0;
    repeat (LAT + 5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
